arbitro_mux_32_8: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit physical-layer byte lane between four 32-bit word requesters. It accepts one word at a time through a valid/ready handshake and serializes it MSB-first, one byte per `clk_4f` cycle. It sits upstream of the lane, so its byte stream is exactly the format `demux_8_32` reassembles into 32-bit words. Back-to-back words are emitted with no idle gap.

---
 rtl/arbitro_mux_32_8.sv | 112 +++++++++++
 tb/tb_arbitro_mux_32_8.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux_32_8.sv
// Round-robin (or fixed-priority) arbiter that serializes one of four 32-bit
// requester words onto an 8-bit lane, MSB first, one byte per clk_4f cycle.
module arbitro_mux_32_8 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic         clk_4f,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  output logic [3:0]   req_ready,
  output logic [7:0]   data_out,
  output logic         valid_out,
  output logic [1:0]   grant,
  output logic         busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0] r_shift, w_shift_nxt;
  logic [7:0]  r_data_out, w_data_out_nxt;
  logic        r_valid_out, w_valid_out_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic [1:0]  r_last_grant, w_last_grant_nxt;
  logic        r_busy, w_busy_nxt;

  logic        w_slot, w_found, w_accept;
  logic [1:0]  w_win, w_idx;
  logic [31:0] w_word;

  // Search order: rotating from last_grant+1, or plain 0..3 for fixed priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = (ROUND_ROBIN != 0) ? r_last_grant + 2'(k + 1) : 2'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_slot    = (r_state == IDLE) || (r_byte_cnt == 2'd3);
  assign w_accept  = w_slot && w_found && reset;
  assign req_ready = w_accept ? (4'b0001 << w_win) : 4'b0000;
  assign w_word    = req_data[32*w_win +: 32];

  always_comb begin
    w_state_nxt      = r_state;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_shift_nxt      = r_shift;
    w_data_out_nxt   = r_data_out;
    w_valid_out_nxt  = r_valid_out;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_busy_nxt       = r_busy;
    if (w_accept) begin
      w_state_nxt      = SEND;
      w_byte_cnt_nxt   = 2'd0;
      w_shift_nxt      = w_word[23:0];
      w_data_out_nxt   = w_word[31:24];
      w_valid_out_nxt  = 1'b1;
      w_grant_nxt      = w_win;
      w_last_grant_nxt = w_win;
      w_busy_nxt       = 1'b1;
    end else if (r_state == SEND) begin
      if (r_byte_cnt != 2'd3) begin
        w_byte_cnt_nxt = r_byte_cnt + 2'd1;
        w_data_out_nxt = r_shift[23:16];
        w_shift_nxt    = {r_shift[15:0], 8'h00};
      end else begin
        // No follow-on word: lane goes idle, grant keeps its last owner.
        w_state_nxt     = IDLE;
        w_byte_cnt_nxt  = 2'd0;
        w_data_out_nxt  = 8'h00;
        w_valid_out_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 24'h0;
      r_data_out   <= 8'h00;
      r_valid_out  <= 1'b0;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd3;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_data_out   <= w_data_out_nxt;
      r_valid_out  <= w_valid_out_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_arbitro_mux_32_8.sv
// Directed bench for arbitro_mux_32_8: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_arbitro_mux_32_8;

  logic         clk_4f = 1'b0;
  logic         reset  = 1'b0;
  logic [3:0]   req_valid = 4'h0;
  logic [127:0] req_data  = '0;
  logic [3:0]   req_ready;
  logic [7:0]   data_out;
  logic         valid_out;
  logic [1:0]   grant;
  logic         busy;

  logic [3:0]   fp_valid = 4'h0;
  logic [127:0] fp_data  = '0;
  logic [3:0]   fp_ready;
  logic [7:0]   fp_dout;
  logic         fp_vout;
  logic [1:0]   fp_grant;
  logic         fp_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk_4f = ~clk_4f;

  arbitro_mux_32_8 #(.ROUND_ROBIN(1)) dut (
    .clk_4f(clk_4f), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out(data_out), .valid_out(valid_out),
    .grant(grant), .busy(busy));

  arbitro_mux_32_8 #(.ROUND_ROBIN(0)) dut_fp (
    .clk_4f(clk_4f), .reset(reset), .req_valid(fp_valid), .req_data(fp_data),
    .req_ready(fp_ready), .data_out(fp_dout), .valid_out(fp_vout),
    .grant(fp_grant), .busy(fp_busy));

  task automatic reset_pulse();
    @(negedge clk_4f);
    reset = 1'b0; req_valid = 4'h0; fp_valid = 4'h0;
    @(negedge clk_4f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 4'hF; req_data = {4{32'hDEADBEEF}};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_4f); #1;
      checks++;
      if (data_out !== 8'h00 || valid_out !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 4'h0 || grant !== 2'd0) begin
        failures++;
        $display("FAIL reset cyc%0d: dout=%h vout=%b busy=%b rdy=%b grant=%0d, need 00 0 0 0000 0",
                 c, data_out, valid_out, busy, req_ready, grant);
      end
    end
    req_valid = 4'h0;
    @(negedge clk_4f);
    reset = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hEE, 8'hFF, 8'hFD, 8'hCC};
    @(negedge clk_4f);
    req_data[31:0] = 32'hEEFFFDCC; req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_ready: got %b need 0001", req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_4f);
      req_valid = 4'h0; #1;
      checks++;
      if (data_out !== exp_b[c] || valid_out !== 1'b1 || grant !== 2'd0 ||
          req_ready !== 4'h0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_byte%0d: dout=%h vout=%b grant=%0d rdy=%b busy=%b, need %h 1 0 0000 1",
                 c, data_out, valid_out, grant, req_ready, busy, exp_b[c]);
      end
    end
    @(negedge clk_4f); #1;
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || busy !== 1'b0 || grant !== 2'd0) begin
      failures++;
      $display("FAIL single_idle: dout=%h vout=%b busy=%b grant=%0d, need 00 0 0 0",
               data_out, valid_out, busy, grant);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] eb;
    logic [1:0] eg;
    reset_pulse();
    @(negedge clk_4f);
    req_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    req_valid = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_4f); #1;
      eg = 2'((c / 4) % 4);
      eb = 8'h11 * (8'(eg) + 8'd1);
      checks++;
      if (data_out !== eb || valid_out !== 1'b1 || grant !== eg ||
          $countones(req_ready) > 1) begin
        failures++;
        $display("FAIL rotation cyc%0d: dout=%h vout=%b grant=%0d rdy=%b, need %h 1 %0d one-hot",
                 c, data_out, valid_out, grant, req_ready, eb, eg);
      end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_fixed_priority();
    logic [7:0] exp_b [4];
    exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    reset_pulse();
    @(negedge clk_4f);
    fp_data = {32'h0, 32'h5A5A5A5A, 32'h0, 32'h0A0B0C0D};
    fp_valid = 4'b0101; #1;
    checks++;
    if (fp_ready !== 4'b0001) begin
      failures++; $display("FAIL fixed_first_ready: got %b need 0001", fp_ready);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_4f); #1;
      checks++;
      if (fp_grant !== 2'd0 || fp_vout !== 1'b1 || fp_dout !== exp_b[c % 4] ||
          fp_ready[2] !== 1'b0) begin
        failures++;
        $display("FAIL fixed cyc%0d: grant=%0d vout=%b dout=%h rdy=%b, need 0 1 %h rdy2=0",
                 c, fp_grant, fp_vout, fp_dout, fp_ready, exp_b[c % 4]);
      end
    end
    fp_valid = 4'h0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    logic [1:0] exp_g [8];
    exp_b = '{8'hEE, 8'hFF, 8'hFD, 8'hCC, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    exp_g = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    reset_pulse();
    @(negedge clk_4f);
    req_data = '0;
    req_data[31:0] = 32'hEEFFFDCC; req_data[63:32] = 32'hA1B2C3D4;
    req_valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_4f);
      if (c == 0) req_valid[0] = 1'b0;
      if (c == 1) req_valid[1] = 1'b1;
      if (c == 4) req_valid[1] = 1'b0;
      #1;
      checks++;
      if (data_out !== exp_b[c] || valid_out !== 1'b1 || grant !== exp_g[c]) begin
        failures++;
        $display("FAIL b2b byte%0d: dout=%h vout=%b grant=%0d, need %h 1 %0d",
                 c, data_out, valid_out, grant, exp_b[c], exp_g[c]);
      end
      if (c == 3) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          failures++; $display("FAIL b2b_slot_ready: got %b need 0010", req_ready);
        end
      end
    end
    @(negedge clk_4f); #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || grant !== 2'd1) begin
      failures++;
      $display("FAIL b2b_idle: vout=%b dout=%h grant=%0d, need 0 00 1", valid_out, data_out, grant);
    end
  endtask

  task automatic test_reset_mid_word();
    reset_pulse();
    @(negedge clk_4f);
    req_data = '0;
    req_data[31:0] = 32'hEEFFFDCC; req_data[127:96] = 32'h3C3C3C3C;
    req_valid = 4'b0001;
    @(negedge clk_4f); req_valid = 4'h0;
    @(negedge clk_4f);
    @(negedge clk_4f); #1;
    checks++;
    if (data_out !== 8'hFD || valid_out !== 1'b1) begin
      failures++; $display("FAIL midrst_pre: dout=%h vout=%b need FD 1", data_out, valid_out);
    end
    req_valid = 4'b1001;
    reset = 1'b0; #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || busy !== 1'b0 ||
        req_ready !== 4'h0 || grant !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async: vout=%b dout=%h busy=%b rdy=%b grant=%0d, need 0 00 0 0000 0",
               valid_out, data_out, busy, req_ready, grant);
    end
    @(negedge clk_4f);
    reset = 1'b1; #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL midrst_ready: got %b need 0001", req_ready);
    end
    @(negedge clk_4f); #1;
    checks++;
    if (grant !== 2'd0 || data_out !== 8'hEE || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL midrst_regrant: grant=%0d dout=%h vout=%b, need 0 EE 1", grant, data_out, valid_out);
    end
    req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) @(negedge clk_4f);
    #1;
    checks++;
    if (grant !== 2'd3 || data_out !== 8'h3C) begin
      failures++; $display("FAIL midrst_next: grant=%0d dout=%h, need 3 3C", grant, data_out);
    end
    req_valid = 4'h0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_rotation();
    test_fixed_priority();
    test_back_to_back();
    test_reset_mid_word();
    repeat (6) @(negedge clk_4f);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
